// File: rtl/reg_share_arbiter_if.sv
// Bundle for the two-client arbiter: requester side and storage-register side.
// slave = the arbiter, master = the clients plus the storage register.
interface reg_share_arbiter_if #(
    parameter int n = 16
);
    logic [1:0]   req;
    logic [1:0]   wr_en;
    logic [1:0]   rd_en;
    logic [n-1:0] wdata0;
    logic [n-1:0] wdata1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [n-1:0] rsp_data;
    logic         busy;
    logic         st_read;
    logic         st_write;
    logic [n-1:0] st_in;
    logic [n-1:0] st_out;

    modport slave (
        input  req, wr_en, rd_en, wdata0, wdata1, st_out,
        output gnt, done, rsp_data, busy, st_read, st_write, st_in
    );

    modport master (
        output req, wr_en, rd_en, wdata0, wdata1, st_out,
        input  gnt, done, rsp_data, busy, st_read, st_write, st_in
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter/sequencer giving two clients exclusive 3-cycle access
// to one shared storage word (grant -> strobe cycle -> capture/done).
module reg_share_arbiter #(
    parameter int n = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_share_arbiter_if.slave   bus
);
    // state   | meaning
    // IDLE    | waiting for a request, arbitrates on each edge
    // ISSUE   | storage strobes driven from the latched op for one cycle
    // CAPTURE | read data sampled, done pulsed, grant released
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic         w_win;
    logic         r_win;
    logic         r_last;
    logic         r_wr;
    logic         r_rd;
    logic [n-1:0] r_wdata;
    logic [1:0]   r_gnt;
    logic [1:0]   r_done;
    logic [n-1:0] r_rsp;

    always_comb begin
        w_next = r_state;
        // On a tie the requester not served last wins; otherwise the lone requester.
        w_win  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
        case (r_state)
            IDLE:    if (|bus.req) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_wdata <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_rsp   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_wr    <= bus.wr_en[w_win];
                        r_rd    <= bus.rd_en[w_win];
                        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                    end
                end
                CAPTURE: begin
                    if (r_rd) r_rsp <= bus.st_out;
                    r_done <= r_win ? 2'b10 : 2'b01;
                    r_gnt  <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded purely from registered state so they cannot glitch.
    assign bus.st_write = (r_state == ISSUE) && r_wr;
    assign bus.st_read  = (r_state == ISSUE) && r_rd;
    assign bus.st_in    = (r_state == ISSUE) ? r_wdata : '0;
    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.rsp_data = r_rsp;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with a behavioural storage register
// and a scoreboard of expected grant/strobe/response per transaction.
module tb_reg_share_arbiter;
    localparam int N = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_share_arbiter_if #(.n(N)) bus ();
    reg_share_arbiter #(.n(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Storage word: written at the strobe edge, output always shows the word.
    logic [N-1:0] st_word;
    always @(posedge clk or posedge reset) begin
        if (reset) st_word <= '0;
        else if (bus.st_write) st_word <= bus.st_in;
    end
    assign bus.st_out = st_word;

    typedef struct {
        logic [1:0]   gnt;
        logic         wr;
        logic         rd;
        logic [N-1:0] wdata;
        logic [N-1:0] rsp;
        logic [N-1:0] word;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] m_word;
    logic [N-1:0] m_rsp;
    logic         m_last;
    int           n_assert = 0;
    int           n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [1:0] req, input logic [1:0] wr, input logic [1:0] rd,
                           input logic [N-1:0] w0, input logic [N-1:0] w1);
        bus.req    = req;
        bus.wr_en  = wr;
        bus.rd_en  = rd;
        bus.wdata0 = w0;
        bus.wdata1 = w1;
    endtask

    task automatic push_txn(input int who, input logic wr, input logic rd, input logic [N-1:0] wd);
        exp_t e;
        e.gnt   = (who == 1) ? 2'b10 : 2'b01;
        e.wr    = wr;
        e.rd    = rd;
        e.wdata = wd;
        if (wr) m_word = wd;
        if (rd) m_rsp = m_word;
        e.rsp   = m_rsp;
        e.word  = m_word;
        m_last  = (who == 1);
        sb.push_back(e);
    endtask

    // Follows one transaction from the negedge before its grant edge to its done cycle.
    task automatic follow(input bit drop);
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.gnt == 2'b00 && k < 8);
        chk("gnt_issue", 32'(bus.gnt), 32'(e.gnt));
        chk("busy_issue", 32'(bus.busy), 32'd1);
        chk("st_write_issue", 32'(bus.st_write), 32'(e.wr));
        chk("st_read_issue", 32'(bus.st_read), 32'(e.rd));
        chk("st_in_issue", 32'(bus.st_in), 32'(e.wdata));
        if (drop) begin
            bus.wdata0 = ~bus.wdata0;
            bus.wdata1 = ~bus.wdata1;
            bus.wr_en  = ~bus.wr_en;
            bus.rd_en  = ~bus.rd_en;
        end
        @(negedge clk);
        chk("gnt_capture", 32'(bus.gnt), 32'(e.gnt));
        chk("strobes_capture", 32'({bus.st_read, bus.st_write}), 32'd0);
        chk("st_in_capture", 32'(bus.st_in), 32'd0);
        chk("done_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'(e.gnt));
        chk("gnt_released", 32'(bus.gnt), 32'd0);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.rsp));
        chk("stored_word", 32'(st_word), 32'(e.word));
        if (drop) begin
            bus.req = 2'b00;
            @(negedge clk);
            chk("done_cleared", 32'(bus.done), 32'd0);
            chk("busy_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("done_onehot", 32'($onehot0(bus.done)), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        set_all(2'b00, 2'b00, 2'b00, '0, '0);
        m_word = '0;
        m_rsp  = '0;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rsp", 32'(bus.rsp_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strobes", 32'({bus.st_read, bus.st_write}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // R0 write
        set_all(2'b01, 2'b01, 2'b00, 16'h3A5C, 16'h0000);
        push_txn(0, 1'b1, 1'b0, 16'h3A5C);
        follow(1'b1);

        // R1 read back
        set_all(2'b10, 2'b00, 2'b10, 16'h0000, 16'h0000);
        push_txn(1, 1'b0, 1'b1, 16'h0000);
        follow(1'b1);

        // Both held: alternating grants, 3-cycle spacing
        set_all(2'b11, 2'b11, 2'b00, 16'h1111, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            if (m_last) push_txn(0, 1'b1, 1'b0, 16'h1111);
            else        push_txn(1, 1'b1, 1'b0, 16'h2222);
        end
        for (int i = 0; i < 4; i++) follow(i == 3);

        // R1 write+read returns the new word
        set_all(2'b10, 2'b10, 2'b10, 16'h0000, 16'hBEEF);
        push_txn(1, 1'b1, 1'b1, 16'hBEEF);
        follow(1'b1);

        // R0 no-op
        set_all(2'b01, 2'b00, 2'b00, 16'h1234, 16'h0000);
        push_txn(0, 1'b0, 1'b0, 16'h1234);
        follow(1'b1);

        // R0 read aborted by reset during CAPTURE
        set_all(2'b01, 2'b00, 2'b01, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("abort_gnt_issue", 32'(bus.gnt), 32'd1);
        chk("abort_st_read", 32'(bus.st_read), 32'd1);
        @(negedge clk);
        chk("abort_gnt_capture", 32'(bus.gnt), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_rsp", 32'(bus.rsp_data), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        bus.req = 2'b00;
        m_word  = '0;
        m_rsp   = '0;
        m_last  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end

        // Tie after reset goes to R0
        set_all(2'b11, 2'b00, 2'b00, 16'hAAAA, 16'h5555);
        push_txn(0, 1'b0, 1'b0, 16'hAAAA);
        follow(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
